cube_accum: RTL



---
 rtl/cube_pkg.sv | 15 +
 rtl/sat_add.sv | 22 ++
 rtl/cube_accum.sv | 99 +++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the cube pipeline: cube sample width/range and the
// accumulator stage FSM encoding.
package cube_pkg;

    localparam int unsigned CUBE_W   = 12;
    localparam int unsigned CUBE_MAX = 3375;

    typedef logic [CUBE_W-1:0] cube_t;

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational unsigned saturating adder: acc + sample, clamped to the
// accumulator range with an overflow flag.
module sat_add
    import cube_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned IN_W  = CUBE_W
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [IN_W-1:0]  i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_overflow
);

    // One extra bit catches the carry out of the accumulator range.
    logic [ACC_W:0] w_full;

    assign w_full     = {1'b0, i_a} + {{(ACC_W + 1 - IN_W){1'b0}}, i_b};
    assign o_overflow = w_full[ACC_W];
    assign o_sum      = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/cube_accum.sv
// Sums blocks of N accepted cube samples and presents each block sum on a
// valid/ready port with sticky per-block saturation.
module cube_accum
    import cube_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IN_W  = CUBE_W,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_in_valid,
    input  logic [IN_W-1:0]  i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_sum,
    output logic             o_out_sat
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat_acc;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_sat;

    logic [ACC_W-1:0] w_sum;
    logic             w_overflow;
    logic             w_accept;

    sat_add #(
        .ACC_W (ACC_W),
        .IN_W  (IN_W)
    ) u_sat_add (
        .i_a        (r_acc),
        .i_b        (i_in_data),
        .o_sum      (w_sum),
        .o_overflow (w_overflow)
    );

    assign o_in_ready = (r_state == ACC) && !i_clear;
    assign w_accept   = i_in_valid && o_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
        end else if (i_clear) begin
            // Abort the block; out_sum/out_sat are left as-is behind out_valid=0.
            r_state     <= ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat_acc   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        if (r_cnt == LAST) begin
                            r_out_sum   <= w_sum;
                            r_out_sat   <= r_sat_acc | w_overflow;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_sat_acc   <= 1'b0;
                            r_state     <= HOLD;
                        end else begin
                            r_acc     <= w_sum;
                            r_sat_acc <= r_sat_acc | w_overflow;
                            r_cnt     <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACC;
                    end
                end
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_sat   = r_out_sat;

endmodule
